// File: rtl/seven_seg_pkg.sv
// Shared types and segment pattern constants for seven-segment readback blocks.
package seven_seg_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned VAL_W = 4;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 8;

   // Segment bus, bit 6 = a ... bit 0 = g, active-high
   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_0 = 7'b1111110;
   localparam seg_t SEG_1 = 7'b0110000;
   localparam seg_t SEG_2 = 7'b1101101;
   localparam seg_t SEG_3 = 7'b1111001;
   localparam seg_t SEG_4 = 7'b0110011;
   localparam seg_t SEG_5 = 7'b1011011;
   localparam seg_t SEG_6 = 7'b1011111;
   localparam seg_t SEG_7 = 7'b1110000;
   localparam seg_t SEG_8 = 7'b1111111;
   localparam seg_t SEG_9 = 7'b1111011;
   localparam seg_t SEG_A = 7'b1110111;
   localparam seg_t SEG_B = 7'b0011111;
   localparam seg_t SEG_C = 7'b1001110;
   localparam seg_t SEG_D = 7'b0111101;
   localparam seg_t SEG_E = 7'b1001111;
   localparam seg_t SEG_F = 7'b1000111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/seven_seg_lookup.sv
// Combinational segment pattern -> {valid, value} decoder.
// SEVEN_SEG_CAPTURE_HEX_EN: also accept the A..F letter patterns.
module seven_seg_lookup
   import seven_seg_pkg::*;
(
   input  seg_t             seg,
   output logic             valid_c,
   output logic [VAL_W-1:0] val_c
);

`ifdef SEVEN_SEG_CAPTURE_HEX_EN
   localparam logic HEX_EN = 1'b1;
`else
   localparam logic HEX_EN = 1'b0;
`endif

   // Table lookup; letters decode only when hex support is built in
   always_comb begin
      valid_c = 1'b1;
      val_c   = '0;
      case (seg)
         SEG_0: val_c = 4'd0;
         SEG_1: val_c = 4'd1;
         SEG_2: val_c = 4'd2;
         SEG_3: val_c = 4'd3;
         SEG_4: val_c = 4'd4;
         SEG_5: val_c = 4'd5;
         SEG_6: val_c = 4'd6;
         SEG_7: val_c = 4'd7;
         SEG_8: val_c = 4'd8;
         SEG_9: val_c = 4'd9;
         SEG_A: begin valid_c = HEX_EN; val_c = HEX_EN ? 4'd10 : 4'd0; end
         SEG_B: begin valid_c = HEX_EN; val_c = HEX_EN ? 4'd11 : 4'd0; end
         SEG_C: begin valid_c = HEX_EN; val_c = HEX_EN ? 4'd12 : 4'd0; end
         SEG_D: begin valid_c = HEX_EN; val_c = HEX_EN ? 4'd13 : 4'd0; end
         SEG_E: begin valid_c = HEX_EN; val_c = HEX_EN ? 4'd14 : 4'd0; end
         SEG_F: begin valid_c = HEX_EN; val_c = HEX_EN ? 4'd15 : 4'd0; end
         default: valid_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// Multiplexed seven-segment bus monitor: synchronize, qualify for stability,
// decode and hand off each digit over valid/ready with a per-digit shadow.
// SEVEN_SEG_CAPTURE_HEX_EN: passed through to the lookup for A..F decoding.
module seven_seg_capture
   import seven_seg_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SEG_W-1:0]        seg,
   input  logic [DIGITS-1:0]       dig_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [VAL_W-1:0]        out_val,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_err,
   output logic [VAL_W*DIGITS-1:0] bcd_regs,
   output logic                    overflow
);

   seg_t              seg_s1, seg_s2;
   logic [DIGITS-1:0] sel_s1, sel_s2;

   state_t            state_q, state_nx;
   seg_t              ref_seg_q, ref_seg_nx;
   logic [DIGITS-1:0] ref_sel_q, ref_sel_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;

   logic              onehot_c, differs_c, restart_c, capture_c;
   logic [IDX_W-1:0]  idx_c;
   logic              dec_valid_c;
   logic [VAL_W-1:0]  dec_val_c;

   // Two-flop synchronizer on segment lines and strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1 <= '0;
         seg_s2 <= '0;
         sel_s1 <= '0;
         sel_s2 <= '0;
      end else begin
         seg_s1 <= seg;
         seg_s2 <= seg_s1;
         sel_s1 <= dig_sel;
         sel_s2 <= sel_s1;
      end
   end

   assign onehot_c  = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - DIGITS'(1))) == '0);
   assign differs_c = (seg_s2 != ref_seg_q) || (sel_s2 != ref_sel_q);

   // One-hot strobe to digit index
   always_comb begin
      idx_c = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sel_s2[i]) idx_c = IDX_W'(i);
      end
   end

   // At capture time the sample always equals the reference, so decode the sample
   seven_seg_lookup u_lookup (
      .seg     (seg_s2),
      .valid_c (dec_valid_c),
      .val_c   (dec_val_c)
   );

   // FSM state, reference pattern and stability counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ref_seg_q <= '0;
         ref_sel_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_nx;
         ref_seg_q <= ref_seg_nx;
         ref_sel_q <= ref_sel_nx;
         cnt_q     <= cnt_nx;
      end
   end

   // Next-state: restart the window on any new strobed pattern, capture once stable
   always_comb begin
      state_nx   = state_q;
      ref_seg_nx = ref_seg_q;
      ref_sel_nx = ref_sel_q;
      cnt_nx     = cnt_q;
      restart_c  = 1'b0;
      capture_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (onehot_c) restart_c = 1'b1;
         end
         ST_SETTLE: begin
            if (!differs_c) begin
               cnt_nx = cnt_q + CNT_W'(1);
               if (cnt_nx == CNT_W'(STABLE_CYCLES)) begin
                  capture_c = 1'b1;
                  state_nx  = ST_HOLD;
               end
            end else if (onehot_c) begin
               restart_c = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (differs_c) begin
               if (onehot_c) restart_c = 1'b1;
               else          state_nx  = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (restart_c) begin
         ref_seg_nx = seg_s2;
         ref_sel_nx = sel_s2;
         cnt_nx     = CNT_W'(1);
         state_nx   = ST_SETTLE;
         if (STABLE_CYCLES == 1) begin
            capture_c = 1'b1;
            state_nx  = ST_HOLD;
         end
      end
   end

   // 1-deep output register, overflow flag and per-digit shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_val   <= '0;
         out_idx   <= '0;
         out_err   <= 1'b0;
         overflow  <= 1'b0;
         bcd_regs  <= '0;
      end else begin
         if (capture_c) begin
            if (!out_valid || out_ready) begin
               out_valid <= 1'b1;
               out_val   <= dec_val_c;
               out_idx   <= idx_c;
               out_err   <= !dec_valid_c;
            end else begin
               overflow  <= 1'b1;
            end
            if (dec_valid_c) begin
               for (int unsigned i = 0; i < DIGITS; i++) begin
                  if (idx_c == IDX_W'(i)) bcd_regs[i*VAL_W +: VAL_W] <= dec_val_c;
               end
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_seven_seg_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic        out_ready;
   logic        out_valid;
   logic [3:0]  out_val;
   logic [2:0]  out_idx;
   logic        out_err;
   logic [15:0] bcd_regs;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seven_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg       (seg),
      .dig_sel   (dig_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_val   (out_val),
      .out_idx   (out_idx),
      .out_err   (out_err),
      .bcd_regs  (bcd_regs),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0]  pats [4];
      logic [3:0]  vals [4];
      logic [15:0] exp_bcd;
      bit          ok;
      bit          seen;

      pats = '{7'b1111011, 7'b1011011, 7'b1111110, 7'b1110000};
      vals = '{4'd9, 4'd5, 4'd0, 4'd7};

      rst_n = 1'b0; seg = '0; dig_sel = '0; out_ready = 1'b0;
      tick(2);
      check("rst_valid", out_valid, 0);
      check("rst_val", out_val, 0);
      check("rst_idx", out_idx, 0);
      check("rst_err", out_err, 0);
      check("rst_bcd", bcd_regs, 0);
      check("rst_ovf", overflow, 0);

      // first capture latency: valid after the sixth edge
      rst_n = 1'b1; dig_sel = 4'b0001; seg = 7'b1111001;
      tick(5);
      check("lat_early", out_valid, 0);
      tick(1);
      check("lat_valid", out_valid, 1);
      check("lat_val", out_val, 3);
      check("lat_idx", out_idx, 0);
      check("lat_err", out_err, 0);
      check("lat_bcd", bcd_regs, 16'h0003);
      tick(3);
      check("hold_valid", out_valid, 1);
      check("hold_val", out_val, 3);
      out_ready = 1'b1;
      tick(1);
      check("xfer_drop", out_valid, 0);
      out_ready = 1'b0;

      // short glitches on digit 1 never qualify
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         dig_sel = 4'b0010;
         seg = (i % 2 == 0) ? 7'b0110000 : 7'b1111111;
         tick(1); if (out_valid) seen = 1'b1;
         tick(1); if (out_valid) seen = 1'b1;
      end
      dig_sel = '0; seg = '0;
      for (int i = 0; i < 4; i++) begin
         tick(1); if (out_valid) seen = 1'b1;
      end
      check("glitch_novalid", seen, 0);
      check("glitch_bcd", bcd_regs, 16'h0003);

      // sweep digits 0..3 with the consumer always ready
      out_ready = 1'b1;
      for (int d = 0; d < 4; d++) begin
         dig_sel = 4'(1 << d);
         seg = pats[d];
         wait_valid(12, ok);
         check("sweep_timeout", ok, 1);
         check("sweep_val", out_val, vals[d]);
         check("sweep_idx", out_idx, d);
         check("sweep_err", out_err, 0);
      end
      tick(1);
      check("sweep_drop", out_valid, 0);
      check("sweep_bcd", bcd_regs, 16'h7059);
      check("sweep_ovf", overflow, 0);

      // letter A on digit 2
      out_ready = 1'b0;
      dig_sel = 4'b0100; seg = 7'b1110111;
      wait_valid(12, ok);
      check("hex_timeout", ok, 1);
      check("hex_idx", out_idx, 2);
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
      check("hex_val", out_val, 10);
      check("hex_err", out_err, 0);
      exp_bcd = 16'h7A59;
`else
      check("hex_val", out_val, 0);
      check("hex_err", out_err, 1);
      exp_bcd = 16'h7059;
`endif
      check("hex_bcd", bcd_regs, exp_bcd);
      out_ready = 1'b1;
      tick(1);
      check("hex_drop", out_valid, 0);
      out_ready = 1'b0;

      // two captures with no consumer: first held, second dropped but shadowed
      dig_sel = 4'b0001; seg = 7'b1111111;
      wait_valid(12, ok);
      check("ovf_timeout", ok, 1);
      check("ovf_first_val", out_val, 8);
      check("ovf_pre", overflow, 0);
      dig_sel = 4'b0010; seg = 7'b1101101;
      tick(10);
      check("ovf_valid", out_valid, 1);
      check("ovf_val", out_val, 8);
      check("ovf_idx", out_idx, 0);
      check("ovf_flag", overflow, 1);
      exp_bcd = {exp_bcd[15:8], 4'd2, 4'd8};
      check("ovf_bcd", bcd_regs, exp_bcd);
      out_ready = 1'b1;
      tick(1);
      check("ovf_drain", out_valid, 0);
      check("ovf_sticky", overflow, 1);
      out_ready = 1'b0;

      // reset pulse while settling on digit 3
      dig_sel = 4'b1000; seg = 7'b0110011;
      tick(3);
      check("mid_settle", out_valid, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_val", out_val, 0);
      check("mid_rst_idx", out_idx, 0);
      check("mid_rst_bcd", bcd_regs, 0);
      check("mid_rst_ovf", overflow, 0);
      #1;
      rst_n = 1'b1;
      tick(5);
      check("post_rst_early", out_valid, 0);
      tick(1);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_val", out_val, 4);
      check("post_rst_idx", out_idx, 3);
      check("post_rst_bcd", bcd_regs, 16'h4000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
